// File: rtl/register_file.sv
// MIPS R2000 architectural register state: 32 GPRs with a combinational write-back
// bypass on both read ports, plus the HI/LO multiply/divide pair.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_register,
  input  logic [DATA_WIDTH-1:0] write_data_reg,
  input  logic [ADDR_WIDTH-1:0] read_register_1,
  input  logic [ADDR_WIDTH-1:0] read_register_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  input  logic                  hilo_write,
  input  logic [DATA_WIDTH-1:0] hi_in,
  input  logic [DATA_WIDTH-1:0] lo_in,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int REG_COUNT = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] gpr_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] gpr_d [REG_COUNT];
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic                  gpr_we;

  assign gpr_we = reg_write && (write_register != '0);

  always_comb begin
    gpr_d = gpr_q;
    if (gpr_we) begin
      gpr_d[write_register] = write_data_reg;
    end
    gpr_d[0] = '0;
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hilo_write) begin
      hi_d = hi_in;
      lo_d = lo_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        gpr_q[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        gpr_q[i] <= gpr_d[i];
      end
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Index 0 is hardwired; bypass lets decode see the value retiring this cycle.
  always_comb begin
    read_data_1 = '0;
    if (rst_n && (read_register_1 != '0)) begin
      if (gpr_we && (write_register == read_register_1)) begin
        read_data_1 = write_data_reg;
      end else begin
        read_data_1 = gpr_q[read_register_1];
      end
    end
  end

  always_comb begin
    read_data_2 = '0;
    if (rst_n && (read_register_2 != '0)) begin
      if (gpr_we && (write_register == read_register_2)) begin
        read_data_2 = write_data_reg;
      end else begin
        read_data_2 = gpr_q[read_register_2];
      end
    end
  end

  assign hi = rst_n ? hi_q : '0;
  assign lo = rst_n ? lo_q : '0;

endmodule
